// File: rtl/add_inv_arbiter.sv
// rtl/add_inv_arbiter.sv - round-robin arbiter feeding a two-stage add-invert-add pipeline
module add_inv_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_z,
    output logic              busy,
    output logic [15:0]       ops_done
);

    logic           s1_valid_q, s1_valid_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic [W-1:0]   s1_a_q, s1_a_d;
    logic [W-1:0]   s1_b_q, s1_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_z_q, rsp_z_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [15:0]    ops_q, ops_d;

    logic           s2_free, s1_adv, can_accept, rsp_fire;
    logic           hi_found, lo_found, gnt_valid;
    logic [IDW-1:0] hi_id, lo_id, gnt_id;
    logic [W-1:0]   a_sel, b_sel, sum, zi;

    assign s2_free    = !rsp_valid_q || rsp_ready;
    assign s1_adv     = s1_valid_q && s2_free;
    assign can_accept = !s1_valid_q || s1_adv;
    assign rsp_fire   = rsp_valid_q && rsp_ready;

    // Lowest valid index above ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_id    = IDW'(i);
                if (IDW'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(i);
                end
            end
        end
    end

    assign gnt_id    = hi_found ? hi_id : lo_id;
    assign gnt_valid = lo_found && can_accept && !rst;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                req_ready[i] = gnt_valid;
                a_sel        = req_a[i*W +: W];
                b_sel        = req_b[i*W +: W];
            end
        end
    end

    assign sum = s1_a_q + s1_b_q;
    assign zi  = ~sum;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        ptr_d       = ptr_q;
        ops_d       = ops_q;
        if (gnt_valid) begin
            s1_valid_d = 1'b1;
            s1_id_d    = gnt_id;
            s1_a_d     = a_sel;
            s1_b_d     = b_sel;
            ptr_d      = gnt_id;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s1_adv) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = s1_id_q;
            rsp_z_d     = s1_a_q + zi;
        end else if (rsp_fire) begin
            rsp_valid_d = 1'b0;
        end
        if (rsp_fire) begin
            ops_d = ops_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            ops_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            ptr_q       <= ptr_d;
            ops_q       <= ops_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign busy      = s1_valid_q || rsp_valid_q;
    assign ops_done  = ops_q;

endmodule
